// File: rtl/dds_para_loader.sv
// dds_para_loader: accepts a 32-bit frequency tuning word, presents it to the
// DDS programming block as two 16-bit halves with a load strobe each, then
// holds state_start high for a fixed programming window and an idle gap.
// Optional feature macro: DDS_PARA_LOADER_DEDUP_EN -- skip commands whose word
// equals the last fully programmed word (prog_done pulse only).
module dds_para_loader #(
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned PROG_CYCLES  = 200,
  parameter int unsigned GAP_CYCLES   = 4
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [31:0] cmd_freq,
  output logic        cmd_ready,
  output logic [15:0] dds_para,
  output logic        dds_choice,
  output logic        dds_load,
  output logic        state_start,
  output logic        prog_done
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PROG_LD  = CNT_W'(PROG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP_LO,
    S_LOAD_LO,
    S_SETUP_HI,
    S_LOAD_HI,
    S_RUN,
    S_GAP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_freq_hi;
  logic             r_cmd_ready;
  logic [15:0]      r_dds_para;
  logic             r_dds_choice;
  logic             r_dds_load;
  logic             r_state_start;
  logic             r_prog_done;

  logic             w_accept;
  logic             w_dup;

  assign w_accept = cmd_valid && r_cmd_ready;

`ifdef DDS_PARA_LOADER_DEDUP_EN
  logic [31:0] r_last;
  logic [15:0] r_freq_lo;
  logic        w_run_done;

  assign w_run_done = (r_state == S_RUN) && (r_cnt == '0);
  assign w_dup      = (cmd_freq == r_last);

  // Remember the low half of the active word and the last word that completed RUN
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_last    <= '0;
      r_freq_lo <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_accept && !w_dup) begin
        r_freq_lo <= cmd_freq[15:0];
      end
      if (w_run_done) begin
        r_last <= {r_freq_hi, r_freq_lo};
      end
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  // Sequencer FSM: one 16-bit down-counter times every timed state
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_freq_hi     <= '0;
      r_cmd_ready   <= 1'b1;
      r_dds_para    <= '0;
      r_dds_choice  <= 1'b0;
      r_dds_load    <= 1'b0;
      r_state_start <= 1'b0;
      r_prog_done   <= 1'b0;
    end else begin
      r_dds_load  <= 1'b0;
      r_prog_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_dup) begin
              r_prog_done <= 1'b1;
            end else begin
              r_freq_hi    <= cmd_freq[31:16];
              r_dds_para   <= cmd_freq[15:0];
              r_dds_choice <= 1'b0;
              r_cnt        <= SETUP_LD;
              r_cmd_ready  <= 1'b0;
              r_state      <= S_SETUP_LO;
            end
          end
        end
        S_SETUP_LO: begin
          if (r_cnt == '0) begin
            r_dds_load <= 1'b1;
            r_state    <= S_LOAD_LO;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_LOAD_LO: begin
          r_dds_para   <= r_freq_hi;
          r_dds_choice <= 1'b1;
          r_cnt        <= SETUP_LD;
          r_state      <= S_SETUP_HI;
        end
        S_SETUP_HI: begin
          if (r_cnt == '0) begin
            r_dds_load <= 1'b1;
            r_state    <= S_LOAD_HI;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_LOAD_HI: begin
          r_state_start <= 1'b1;
          r_cnt         <= PROG_LD;
          r_state       <= S_RUN;
        end
        S_RUN: begin
          if (r_cnt == '0) begin
            r_state_start <= 1'b0;
            if (GAP_CYCLES == 0) begin
              r_prog_done <= 1'b1;
              r_cmd_ready <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_cnt   <= GAP_LD;
              r_state <= S_GAP;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_GAP: begin
          if (r_cnt == '0) begin
            r_prog_done <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state_start <= 1'b0;
          r_cmd_ready   <= 1'b1;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign dds_para    = r_dds_para;
  assign dds_choice  = r_dds_choice;
  assign dds_load    = r_dds_load;
  assign state_start = r_state_start;
  assign prog_done   = r_prog_done;

endmodule

// File: tb/tb_dds_para_loader.sv
// Scoreboard bench for dds_para_loader: two instances (default timing, and
// SETUP_CYCLES=1 / GAP_CYCLES=0); one is selected and monitored at a time.
module tb_dds_para_loader;

  localparam int K_LOAD = 0;
  localparam int K_RISE = 1;
  localparam int K_FALL = 2;
  localparam int K_DONE = 3;
  localparam int PROG   = 200;

  typedef struct {
    int          kind;
    int          cyc;
    logic [15:0] para;
    logic        choice;
  } ev_t;

  logic        clk_sys = 1'b0;
  logic        rst     = 1'b0;
  logic        valid   = 1'b0;
  logic [31:0] freq    = '0;
  logic        sel     = 1'b0;

  logic        ready0, choice0, load0, start0, done0;
  logic        ready1, choice1, load1, start1, done1;
  logic [15:0] para0, para1;
  logic        m_ready, m_choice, m_load, m_start, m_done;
  logic [15:0] m_para;

  ev_t         sb[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          acc_cyc = 0;
  int          prev_acc_cyc = 0;
  logic [31:0] last_prog = '0;
  logic [31:0] pend_last = '0;
  bit          pend_v = 0;
  logic        prev_start = 1'b0;

  always #5 clk_sys = ~clk_sys;

  dds_para_loader u_dut0 (
    .clk_sys(clk_sys), .rst(rst), .cmd_valid(valid & ~sel), .cmd_freq(freq),
    .cmd_ready(ready0), .dds_para(para0), .dds_choice(choice0),
    .dds_load(load0), .state_start(start0), .prog_done(done0)
  );

  dds_para_loader #(.SETUP_CYCLES(1), .PROG_CYCLES(PROG), .GAP_CYCLES(0)) u_dut1 (
    .clk_sys(clk_sys), .rst(rst), .cmd_valid(valid & sel), .cmd_freq(freq),
    .cmd_ready(ready1), .dds_para(para1), .dds_choice(choice1),
    .dds_load(load1), .state_start(start1), .prog_done(done1)
  );

  assign m_ready  = sel ? ready1  : ready0;
  assign m_para   = sel ? para1   : para0;
  assign m_choice = sel ? choice1 : choice0;
  assign m_load   = sel ? load1   : load0;
  assign m_start  = sel ? start1  : start0;
  assign m_done   = sel ? done1   : done0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic string kname(input int k);
    case (k)
      K_LOAD:  return "dds_load";
      K_RISE:  return "start_rise";
      K_FALL:  return "start_fall";
      default: return "prog_done";
    endcase
  endfunction

  task automatic push_ev(input int k, input int c, input logic [15:0] p, input logic ch);
    ev_t e;
    e.kind = k; e.cyc = c; e.para = p; e.choice = ch;
    sb.push_back(e);
  endtask

  // Expected event list for a command accepted at the edge ending cycle c0
  task automatic push_txn();
    int s, g, c0;
    s = sel ? 1 : 2;
    g = sel ? 0 : 4;
    c0 = cyc;
    prev_acc_cyc = acc_cyc;
    acc_cyc = c0;
    acc_cnt++;
`ifdef DDS_PARA_LOADER_DEDUP_EN
    if (freq == last_prog) begin
      push_ev(K_DONE, c0 + 1, '0, 1'b0);
      return;
    end
`endif
    push_ev(K_LOAD, c0 + s + 1,     freq[15:0],  1'b0);
    push_ev(K_LOAD, c0 + 2 * s + 2, freq[31:16], 1'b1);
    push_ev(K_RISE, c0 + 2 * s + 3, '0, 1'b0);
    push_ev(K_FALL, c0 + 2 * s + 3 + PROG, '0, 1'b0);
    push_ev(K_DONE, c0 + 2 * s + 3 + PROG + g, '0, 1'b0);
    pend_last = freq;
    pend_v = 1;
  endtask

  task automatic observe(input int k);
    ev_t e;
    chk({kname(k), "_expected"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({kname(k), "_kind"}, 32'(k), 32'(e.kind));
      chk({kname(k), "_cycle"}, 32'(cyc), 32'(e.cyc));
      if (k == K_LOAD) begin
        chk("dds_para_at_load", 32'(m_para), 32'(e.para));
        chk("dds_choice_at_load", 32'(m_choice), 32'(e.choice));
      end
      if (e.kind == K_FALL && pend_v) begin
        last_prog = pend_last;
        pend_v = 0;
      end
    end
  endtask

  always @(posedge clk_sys) cyc++;

  // Monitor: pop/compare DUT events, then push expectations for new acceptances
  always @(negedge clk_sys) begin
    if (rst) begin
      sb.delete();
      pend_v = 0;
      last_prog = '0;
      prev_start = 1'b0;
    end else begin
      if (m_load) observe(K_LOAD);
      if (m_start && !prev_start) observe(K_RISE);
      if (!m_start && prev_start) observe(K_FALL);
      if (m_done) observe(K_DONE);
      prev_start = m_start;
      chk("cmd_ready", 32'(m_ready), 32'(sb.size() == 0));
      if (valid && m_ready) push_txn();
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cmd_ready"},   32'(m_ready),  32'd1);
    chk({tag, "_dds_para"},    32'(m_para),   32'd0);
    chk({tag, "_dds_choice"},  32'(m_choice), 32'd0);
    chk({tag, "_dds_load"},    32'(m_load),   32'd0);
    chk({tag, "_state_start"}, 32'(m_start),  32'd0);
    chk({tag, "_prog_done"},   32'(m_done),   32'd0);
  endtask

  task automatic do_reset(input logic new_sel);
    @(posedge clk_sys); #2;
    rst = 1'b1;
    sel = new_sel;
    #1;
    check_reset_vals("rst");
    repeat (2) @(posedge clk_sys);
    #1 rst = 1'b0;
  endtask

  task automatic send(input logic [31:0] f);
    int start, n;
    start = acc_cnt;
    n = 0;
    valid = 1'b1;
    freq = f;
    while (acc_cnt == start && n < 20) begin
      @(posedge clk_sys); #1;
      n++;
    end
    valid = 1'b0;
    chk("accepted", 32'(acc_cnt - start), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || !m_ready) && n < budget) begin
      @(posedge clk_sys); #1;
      n++;
    end
    chk("reached_idle", 32'(sb.size() == 0 && m_ready), 32'd1);
    repeat (2) @(posedge clk_sys);
    #1;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 check_reset_vals("por");
    repeat (3) @(posedge clk_sys);
    #1 rst = 1'b0;

    // single command, default timing
    send(32'h1234_ABCD);
    wait_idle(400);

    // cmd_valid held high across two commands
    begin
      int start, n;
      start = acc_cnt;
      n = 0;
      valid = 1'b1;
      freq = 32'h0000_0001;
      while (acc_cnt == start && n < 20) begin
        @(posedge clk_sys); #1; n++;
      end
      freq = 32'hFFFF_FFFF;
      n = 0;
      while (acc_cnt == start + 1 && n < 400) begin
        @(posedge clk_sys); #1; n++;
      end
      valid = 1'b0;
      chk("b2b_accepts", 32'(acc_cnt - start), 32'd2);
      chk("b2b_period", 32'(acc_cyc - prev_acc_cyc), 32'd211);
    end
    wait_idle(400);

    // reset asserted during RUN (cycle 100), then a fresh command
    send(32'hCAFE_0001);
    begin
      int n;
      n = 0;
      while (cyc < acc_cyc + 100 && n < 200) begin
        @(posedge clk_sys); #1; n++;
      end
    end
    chk("pre_rst_state_start", 32'(m_start), 32'd1);
    chk("pre_rst_dds_para", 32'(m_para), 32'h0000_CAFE);
    #1 rst = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    repeat (2) @(posedge clk_sys);
    #1 rst = 1'b0;
    send(32'h0BAD_F00D);
    wait_idle(400);

    // same word twice, then zero right after reset
    send(32'h0555_0000);
    wait_idle(400);
    send(32'h0555_0000);
    wait_idle(400);
    do_reset(1'b0);
    send(32'h0000_0000);
    wait_idle(400);

    // SETUP_CYCLES=1, GAP_CYCLES=0 instance
    do_reset(1'b1);
    send(32'h89AB_CDEF);
    wait_idle(400);
    send(32'h1357_2468);
    wait_idle(400);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
